arb_req_tracker: RTL
====================

ARB_REQ_TRACKER -- requirements
Module: arb_req_tracker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of requesting clients.
REQ-002 The block SHALL have parameter CNT_W, default 2, meaning the width of each client's pending counter (max 2^CNT_W-1).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port req_pulse  input  WIDTH  one-cycle request strobes from clients, one bit per client.
REQ-006 The block SHALL have port req  output  WIDTH  request vector driven to a fixed-priority arbiter.
REQ-007 The block SHALL have port grant  input  WIDTH  one-hot-or-zero grant returned by the arbiter, sampled same cycle as req.
REQ-008 The block SHALL have port pend_full  output  WIDTH  per-client counter-at-maximum flag.
REQ-009 The block SHALL have port drop_err  output  1  sticky flag, a strobe was lost to a full counter.
REQ-010 The block SHALL have port grant_err  output  1  sticky flag, illegal grant observed (see Configuration).

Function
REQ-011 Each client i SHALL own a registered counter cnt[i] of CNT_W bits counting outstanding strobes.
REQ-012 req[i] SHALL equal (cnt[i] != 0), derived only from registered state, no combinational path from req_pulse or grant.
REQ-013 A grant is accepted for client i when grant[i] && req[i]; accepted grant decrements cnt[i] by 1 at the next edge.
REQ-014 req_pulse[i] with cnt[i] below maximum SHALL increment cnt[i] by 1 at the next edge.
REQ-015 Simultaneous accepted grant and strobe on the same client SHALL leave cnt[i] unchanged and SHALL NOT count as a drop.
REQ-016 Strobe on a client with cnt[i] at maximum and no accepted grant SHALL be discarded, cnt[i] held, drop_err set next edge.
REQ-017 grant[i] with req[i]=0 SHALL never decrement (no underflow; counter never wraps below 0 or above maximum).
REQ-018 Latency: strobe at edge N SHALL make req[i]=1 visible after edge N; last accepted grant at edge N SHALL drop req[i] after edge N.
REQ-019 pend_full[i] SHALL equal (cnt[i] == 2^CNT_W-1), registered-derived.
REQ-020 drop_err and grant_err SHALL remain set until rst; no other clear mechanism.
REQ-021 Clients are independent; one client's full or error condition SHALL NOT affect another client's counting.

Reset
REQ-022 Asserting rst SHALL immediately, without clk, clear all cnt[i], so req=0, pend_full=0, drop_err=0, grant_err=0.
REQ-023 Strobes and grants present while rst is high SHALL be ignored; counting resumes on the first rising edge after rst deasserts.
REQ-024 Reset mid-operation SHALL discard all outstanding counts; no pending request survives reset.

Configuration
REQ-025 Macro ARB_REQ_TRACKER_GRANT_CHECK_EN SHALL control grant checking.
REQ-026 With the macro defined, grant_err SHALL set next edge when grant has more than one bit set, or any grant[i]=1 with req[i]=0; illegal cycles still decrement only accepted (grant[i] && req[i]) clients.
REQ-027 Without the macro, grant_err SHALL be tied to 0 and no checking logic SHALL be present; decrement behaviour unchanged.

Verification (WIDTH=4, CNT_W=2, check macro defined)
REQ-028 rst pulse mid-run with cnt=3 on client 0 -> req=0000, pend_full=0000, both errors 0 immediately, before next clk edge.
REQ-029 req_pulse=0001 for 3 cycles, grant=0 -> req=0001, pend_full=0001; 4th strobe -> cnt stays 3, drop_err=1.
REQ-030 cnt[0]=2, grant=0001 each cycle -> req=0001 for 2 cycles then 0000; further grant=0001 -> cnt stays 0, grant_err=1.
REQ-031 cnt[1]=3, req_pulse=0010 and grant=0010 same cycle -> cnt[1] stays 3, drop_err stays 0.
REQ-032 req=1100, grant=1100 -> grant_err=1, cnt[2] and cnt[3] each decrement by 1.
REQ-033 Macro undefined, repeat REQ-030 and REQ-032 stimulus -> grant_err stays 0, counts identical to the macro-defined run.

Source files
------------

// File: rtl/arb_req_tracker.sv
`default_nettype none
// ============================================================================
// Module      : arb_req_tracker
// Description : Per-client pending-request tracker sitting in front of a
//               fixed-priority arbiter. Each client owns a saturating counter
//               of outstanding one-cycle strobes. req is asserted while the
//               count is non-zero. An accepted grant retires one request.
//               Lost strobes and, optionally, illegal grants raise sticky
//               error flags.
// Options     : define ARB_REQ_TRACKER_GRANT_CHECK_EN to enable grant_err
//               checking (multi-hot grant, or grant to a non-requesting
//               client). When undefined, grant_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_req_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_pulse,
  output logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] grant,
  output logic [WIDTH-1:0] pend_full,
  output logic             drop_err,
  output logic             grant_err
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_drop;
  logic             r_drop_err;

  // A grant only counts against a client that is actually requesting, which
  // makes underflow impossible regardless of what the arbiter returns.
  assign w_accept = grant & req;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_client
      // Outputs come straight from registered counter state.
      assign req[i]       = (r_cnt[i] != '0);
      assign pend_full[i] = (r_cnt[i] == C_CNT_MAX);

      // A strobe is lost only when the counter is saturated and no grant
      // frees a slot in the same cycle.
      assign w_drop[i] = req_pulse[i] & ~w_accept[i] & pend_full[i];

      // Saturating up/down counter; strobe plus accepted grant cancel out.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt[i] <= '0;
        end else begin
          if (req_pulse[i] && !w_accept[i] && !pend_full[i]) begin
            r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
          end else if (w_accept[i] && !req_pulse[i]) begin
            r_cnt[i] <= r_cnt[i] - C_CNT_ONE;
          end
        end
      end
    end
  endgenerate

  // Sticky record of any discarded strobe; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_err <= 1'b0;
    end else if (|w_drop) begin
      r_drop_err <= 1'b1;
    end
  end

  assign drop_err = r_drop_err;

`ifdef ARB_REQ_TRACKER_GRANT_CHECK_EN
  logic             r_grant_err;
  logic             w_grant_multi;
  logic             w_grant_orphan;
  logic [WIDTH-1:0] w_grant_m1;

  // x & (x-1) clears the lowest set bit; anything left means multi-hot.
  assign w_grant_m1     = grant - {{(WIDTH-1){1'b0}}, 1'b1};
  assign w_grant_multi  = |(grant & w_grant_m1);
  assign w_grant_orphan = |(grant & ~req);

  // Sticky record of any illegal grant pattern; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_err <= 1'b0;
    end else if (w_grant_multi || w_grant_orphan) begin
      r_grant_err <= 1'b1;
    end
  end

  assign grant_err = r_grant_err;
`else
  assign grant_err = 1'b0;
`endif

endmodule
`default_nettype wire
